// File: rtl/softmax_lut_pkg.sv
// Shared constants, table-depth helper and arithmetic widths for the
// softmax piecewise-linear lookup unit.
package softmax_lut_pkg;

    localparam int IN_W_DEF   = 12;
    localparam int IDX_W_DEF  = 4;
    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = IN_W_DEF - IDX_W_DEF;

    typedef logic signed [DATA_W_DEF:0]            diff_t;
    typedef logic signed [DATA_W_DEF+FRAC_W_DEF:0] prod_t;

    function automatic int tbl_depth(input int idx_w);
        return (1 << idx_w) + 1;
    endfunction

endpackage

// File: rtl/softmax_lut_interp_if.sv
// Config port plus input/output valid-ready streams of the lookup unit.
interface softmax_lut_interp_if
    import softmax_lut_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cfg_we;
    logic [IDX_W:0]    cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_x;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_y;
    logic              busy;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, in_x, out_ready,
        input  cfg_err, in_ready, out_valid, out_y, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_x, out_ready,
        output cfg_err, in_ready, out_valid, out_y, busy
    );
endinterface

// File: rtl/softmax_lut_regfile.sv
// Interpolation table: one write port, two combinational reads of adjacent
// entries (idx, idx+1); cleared by the asynchronous reset.
module softmax_lut_regfile
    import softmax_lut_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W:0]    waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rd_lo,
    output logic [DATA_W-1:0] rd_hi
);
    localparam int DEPTH = tbl_depth(IDX_W);

    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W:0]    lo_addr;
    logic [IDX_W:0]    hi_addr;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // The top segment reads entry 2^IDX_W, hence the extra address bit.
    assign lo_addr = {1'b0, raddr};
    assign hi_addr = lo_addr + (IDX_W+1)'(1);
    assign rd_lo   = mem_q[lo_addr];
    assign rd_hi   = mem_q[hi_addr];

endmodule

// File: rtl/softmax_lut_interp.sv
// Three-stage pipelined piecewise-linear lookup with runtime-loadable table
// and valid/ready flow control on both sides.
module softmax_lut_interp
    import softmax_lut_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    softmax_lut_interp_if.slave bus
);
    localparam int FRAC_W = IN_W - IDX_W;
    localparam int PROD_W = DATA_W + 1 + FRAC_W;

    function automatic logic signed [PROD_W-1:0] scale_diff(
        input logic [DATA_W-1:0] lo,
        input logic [DATA_W-1:0] hi,
        input logic [FRAC_W-1:0] frac
    );
        logic signed [DATA_W:0]   diff;
        logic signed [PROD_W-1:0] diff_ext;
        logic signed [PROD_W-1:0] frac_ext;
        diff     = $signed({1'b0, hi}) - $signed({1'b0, lo});
        diff_ext = PROD_W'(diff);
        frac_ext = PROD_W'({1'b0, frac});
        return diff_ext * frac_ext;
    endfunction

    // Arithmetic shift floors; the sum stays within [lo, hi] so no clamp.
    function automatic logic [DATA_W-1:0] interp_round(
        input logic [DATA_W-1:0]        lo,
        input logic signed [PROD_W-1:0] prod
    );
        return lo + DATA_W'(prod >>> FRAC_W);
    endfunction

    logic                     advance, accept, busy, addr_ok, cfg_ok;
    logic [DATA_W-1:0]        rd_lo, rd_hi;
    logic                     vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q, vld_p3_d, vld_p3_q;
    logic [DATA_W-1:0]        lo_p1_d, lo_p1_q, hi_p1_d, hi_p1_q;
    logic [FRAC_W-1:0]        frac_p1_d, frac_p1_q;
    logic [DATA_W-1:0]        lo_p2_d, lo_p2_q;
    logic signed [PROD_W-1:0] prod_p2_d, prod_p2_q;
    logic [DATA_W-1:0]        out_y_d, out_y_q;
    logic                     cfg_err_d, cfg_err_q;

    softmax_lut_regfile #(.IDX_W(IDX_W), .DATA_W(DATA_W)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cfg_ok),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_wdata),
        .raddr (bus.in_x[IN_W-1:FRAC_W]),
        .rd_lo (rd_lo),
        .rd_hi (rd_hi)
    );

    always_comb begin
        busy      = vld_p1_q || vld_p2_q || vld_p3_q;
        advance   = !vld_p3_q || bus.out_ready;
        accept    = bus.in_valid && advance && !bus.cfg_we;
        addr_ok   = !bus.cfg_addr[IDX_W] || (bus.cfg_addr[IDX_W-1:0] == '0);
        cfg_ok    = bus.cfg_we && !busy && addr_ok;
        cfg_err_d = bus.cfg_we && !cfg_ok;

        vld_p1_d  = vld_p1_q;
        lo_p1_d   = lo_p1_q;
        hi_p1_d   = hi_p1_q;
        frac_p1_d = frac_p1_q;
        vld_p2_d  = vld_p2_q;
        lo_p2_d   = lo_p2_q;
        prod_p2_d = prod_p2_q;
        vld_p3_d  = vld_p3_q;
        out_y_d   = out_y_q;
        if (advance) begin
            // p1: table fetch
            vld_p1_d  = accept;
            lo_p1_d   = rd_lo;
            hi_p1_d   = rd_hi;
            frac_p1_d = bus.in_x[FRAC_W-1:0];
            // p2: scaled slope
            vld_p2_d  = vld_p1_q;
            lo_p2_d   = lo_p1_q;
            prod_p2_d = scale_diff(lo_p1_q, hi_p1_q, frac_p1_q);
            // p3: base plus offset
            vld_p3_d  = vld_p2_q;
            if (vld_p2_q) begin
                out_y_d = interp_round(lo_p2_q, prod_p2_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
            out_y_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            vld_p3_q  <= vld_p3_d;
            out_y_q   <= out_y_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_ff @(posedge clk) begin
        lo_p1_q   <= lo_p1_d;
        hi_p1_q   <= hi_p1_d;
        frac_p1_q <= frac_p1_d;
        lo_p2_q   <= lo_p2_d;
        prod_p2_q <= prod_p2_d;
    end

    assign bus.in_ready  = advance && !bus.cfg_we;
    assign bus.out_valid = vld_p3_q;
    assign bus.out_y     = out_y_q;
    assign bus.busy      = busy;
    assign bus.cfg_err   = cfg_err_q;

endmodule
